matmul_sequencer: RTL and testbench

Sequences one k×k FP32 matrix product C = A·B through the row-parallel multiply/accumulate datapath.
- Fetches A cells and B rows from a single-port word memory.
- Issues (cell, row) pairs to the datapath with stb/ack handshakes.
- Captures each accumulated output row and writes it back as row i of C.
- Sits between the coprocessor command interface (start/bases/done) and the datapath plus memory.

---
 rtl/matmul_pkg.sv | 24 ++
 rtl/matmul_addr_gen.sv | 17 +
 rtl/matmul_sequencer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared state encoding, word width and row-major address helper for the
// matrix-multiply sequencer.
package matmul_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_B  = 3'd1,
    FETCH_A  = 3'd2,
    WAIT_RDY = 3'd3,
    ISSUE    = 3'd4,
    WAIT_ROW = 3'd5,
    WRITE_C  = 3'd6,
    DONE     = 3'd7
  } state_e;

  // Row-major word address of (row, col) in a k-wide matrix; callers truncate to their width.
  function automatic logic [31:0] addr_calc(input logic [31:0] base, input logic [31:0] row,
                                            input logic [31:0] col, input logic [31:0] k);
    return base + row * k + col;
  endfunction

endpackage

// File: rtl/matmul_addr_gen.sv
// Combinational row-major address generator: base + r*K + c, wrapping at AW bits.
module matmul_addr_gen
  import matmul_pkg::*;
#(
  parameter int K  = 2,
  parameter int AW = 16,
  parameter int CW = 2
) (
  input  logic [AW-1:0] i_base,
  input  logic [CW-1:0] i_r,
  input  logic [CW-1:0] i_c,
  output logic [AW-1:0] o_addr
);

  assign o_addr = AW'(addr_calc(32'(i_base), 32'(i_r), 32'(i_c), 32'(K)));

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences one KxK FP32 product C = A*B: fetches B rows and A cells from word memory,
// hands (cell, row) pairs to the row-parallel datapath and writes accumulated rows back.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int K  = 2,
  parameter int AW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     base_a,
  input  logic [AW-1:0]     base_b,
  input  logic [AW-1:0]     base_c,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_rd_en,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              mem_wr_en,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [WORD_W*K-1:0] dp_row,
  output logic              dp_row_stb,
  input  logic              dp_row_ack,
  output logic [WORD_W-1:0] dp_cell,
  output logic              dp_cell_stb,
  input  logic              dp_cell_ack,
  input  logic              dp_ready,
  input  logic [WORD_W*K-1:0] dp_out_row,
  input  logic              dp_out_stb
);

  localparam int CW = $clog2(K + 1);
  localparam int RW = WORD_W * K;
  localparam logic [CW-1:0] KC  = CW'(K);
  localparam logic [CW-1:0] KM1 = CW'(K - 1);

  state_e              r_state;
  logic [AW-1:0]       r_base_a;
  logic [AW-1:0]       r_base_b;
  logic [AW-1:0]       r_base_c;
  logic [CW-1:0]       r_i;
  logic [CW-1:0]       r_j;
  logic [CW-1:0]       r_n;
  logic                r_rdy_f;
  logic                r_row_acked;
  logic                r_cell_acked;
  logic                r_rd_issued;
  logic                r_rd_cell_p0;
  logic [CW-1:0]       r_rd_lane_p0;
  logic                r_rd_vld_p1;
  logic                r_rd_cell_p1;
  logic [CW-1:0]       r_rd_lane_p1;
  logic [RW-1:0]       r_row;
  logic [RW-1:0]       r_wb;
  logic [WORD_W-1:0]   r_cell;
  logic                r_row_stb;
  logic                r_cell_stb;
  logic                r_busy;
  logic                r_done;
  logic [AW-1:0]       r_mem_addr;
  logic                r_mem_rd_en;
  logic                r_mem_wr_en;
  logic [WORD_W-1:0]   r_mem_wdata;

  logic [AW-1:0]       w_ag_base;
  logic [CW-1:0]       w_ag_r;
  logic [CW-1:0]       w_ag_c;
  logic [AW-1:0]       w_ag_addr;
  logic                w_row_done;
  logic                w_cell_done;
  logic                w_rdy;

  // One shared address generator; the operand set follows the current phase.
  always_comb begin
    w_ag_base = r_base_b;
    w_ag_r    = r_j;
    w_ag_c    = r_n;
    case (r_state)
      FETCH_A: begin
        w_ag_base = r_base_a;
        w_ag_r    = r_i;
        w_ag_c    = r_j;
      end
      WRITE_C: begin
        w_ag_base = r_base_c;
        w_ag_r    = r_i;
        w_ag_c    = r_n;
      end
      default: ;
    endcase
  end

  matmul_addr_gen #(
    .K  (K),
    .AW (AW),
    .CW (CW)
  ) u_addr_gen (
    .i_base (w_ag_base),
    .i_r    (w_ag_r),
    .i_c    (w_ag_c),
    .o_addr (w_ag_addr)
  );

  assign w_row_done  = r_row_acked  | (r_row_stb  & dp_row_ack);
  assign w_cell_done = r_cell_acked | (r_cell_stb & dp_cell_ack);
  assign w_rdy       = r_rdy_f | dp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_base_a     <= '0;
      r_base_b     <= '0;
      r_base_c     <= '0;
      r_i          <= '0;
      r_j          <= '0;
      r_n          <= '0;
      r_rdy_f      <= 1'b0;
      r_row_acked  <= 1'b0;
      r_cell_acked <= 1'b0;
      r_rd_issued  <= 1'b0;
      r_rd_cell_p0 <= 1'b0;
      r_rd_lane_p0 <= '0;
      r_rd_vld_p1  <= 1'b0;
      r_rd_cell_p1 <= 1'b0;
      r_rd_lane_p1 <= '0;
      r_row        <= '0;
      r_cell       <= '0;
      r_row_stb    <= 1'b0;
      r_cell_stb   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_rd_en  <= 1'b0;
      r_mem_wr_en  <= 1'b0;
      r_mem_wdata  <= '0;
    end else begin
      r_mem_rd_en <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;

      // p0 -> p1: memory answers one cycle after the read strobe, captured here.
      r_rd_vld_p1  <= r_mem_rd_en;
      r_rd_cell_p1 <= r_rd_cell_p0;
      r_rd_lane_p1 <= r_rd_lane_p0;
      if (r_rd_vld_p1) begin
        if (r_rd_cell_p1) r_cell <= mem_rdata;
        else              r_row[WORD_W*r_rd_lane_p1 +: WORD_W] <= mem_rdata;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_base_a <= base_a;
            r_base_b <= base_b;
            r_base_c <= base_c;
            r_i      <= '0;
            r_j      <= '0;
            r_n      <= '0;
            r_busy   <= 1'b1;
            r_state  <= FETCH_B;
          end
        end
        FETCH_B: begin
          if (r_n != KC) begin
            r_mem_rd_en  <= 1'b1;
            r_mem_addr   <= w_ag_addr;
            r_rd_cell_p0 <= 1'b0;
            r_rd_lane_p0 <= r_n;
            r_n          <= r_n + CW'(1);
          end
          if (r_rd_vld_p1 && !r_rd_cell_p1 && r_rd_lane_p1 == KM1) begin
            r_rd_issued <= 1'b0;
            r_state     <= FETCH_A;
          end
        end
        FETCH_A: begin
          if (!r_rd_issued) begin
            r_mem_rd_en  <= 1'b1;
            r_mem_addr   <= w_ag_addr;
            r_rd_cell_p0 <= 1'b1;
            r_rd_issued  <= 1'b1;
          end else if (r_rd_vld_p1 && r_rd_cell_p1) begin
            r_state <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (w_rdy) begin
            r_row_stb    <= 1'b1;
            r_cell_stb   <= 1'b1;
            r_row_acked  <= 1'b0;
            r_cell_acked <= 1'b0;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_row_stb && dp_row_ack) begin
            r_row_stb   <= 1'b0;
            r_row_acked <= 1'b1;
          end
          if (r_cell_stb && dp_cell_ack) begin
            r_cell_stb   <= 1'b0;
            r_cell_acked <= 1'b1;
          end
          if (w_row_done && w_cell_done) begin
            r_rdy_f <= 1'b0;
            r_j     <= r_j + CW'(1);
            r_n     <= '0;
            r_state <= (r_j == KM1) ? WAIT_ROW : FETCH_B;
          end
        end
        WAIT_ROW: begin
          if (dp_out_stb) begin
            r_n     <= '0;
            r_state <= WRITE_C;
          end
        end
        WRITE_C: begin
          if (r_n != KC) begin
            r_mem_wr_en <= 1'b1;
            r_mem_addr  <= w_ag_addr;
            r_mem_wdata <= r_wb[WORD_W*r_n +: WORD_W];
            r_n         <= r_n + CW'(1);
          end else begin
            r_j <= '0;
            r_n <= '0;
            r_i <= r_i + CW'(1);
            if (r_i == KM1) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= FETCH_B;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // A ready pulse wins over the clear at ISSUE completion.
      if (dp_ready) r_rdy_f <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == WAIT_ROW && dp_out_stb) r_wb <= dp_out_row;
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign mem_addr    = r_mem_addr;
  assign mem_rd_en   = r_mem_rd_en;
  assign mem_wr_en   = r_mem_wr_en;
  assign mem_wdata   = r_mem_wdata;
  assign dp_row      = r_row;
  assign dp_row_stb  = r_row_stb;
  assign dp_cell     = r_cell;
  assign dp_cell_stb = r_cell_stb;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: word memory, behavioural FP32 datapath and a write scoreboard.
module tb_matmul_sequencer;

  localparam int K  = 2;
  localparam int AW = 16;
  localparam int W  = 32;
  localparam logic [31:0] C_EXP [4] = '{32'h41980000, 32'h41B00000, 32'h422C0000, 32'h42480000};

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW-1:0]   base_a, base_b, base_c;
  logic            busy, done;
  logic [AW-1:0]   mem_addr;
  logic            mem_rd_en, mem_wr_en;
  logic [W-1:0]    mem_rdata, mem_wdata;
  logic [W*K-1:0]  dp_row;
  logic            dp_row_stb, dp_row_ack;
  logic [W-1:0]    dp_cell;
  logic            dp_cell_stb, dp_cell_ack;
  logic            dp_ready;
  logic [W*K-1:0]  dp_out_row;
  logic            dp_out_stb;

  matmul_sequencer #(.K(K), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .dp_row(dp_row), .dp_row_stb(dp_row_stb), .dp_row_ack(dp_row_ack),
    .dp_cell(dp_cell), .dp_cell_stb(dp_cell_stb), .dp_cell_ack(dp_cell_ack),
    .dp_ready(dp_ready), .dp_out_row(dp_out_row), .dp_out_stb(dp_out_stb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mem [0:65535];
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          issue_cnt = 0;
  int          row_delay = 0;
  bit          slow_first = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  // Memory with one-cycle read latency (X otherwise) plus write scoreboard monitor.
  initial begin
    logic          pend;
    logic [AW-1:0] pend_addr;
    wr_t           e;
    pend = 1'b0;
    pend_addr = '0;
    mem_rdata = 'x;
    forever begin
      @(negedge clk);
      mem_rdata = pend ? mem[pend_addr] : 'x;
      pend = mem_rd_en;
      pend_addr = mem_addr;
      check("rd_wr_exclusive", {63'd0, mem_rd_en & mem_wr_en}, 64'd0);
      if (!mem_rd_en && !mem_wr_en) check("idle_addr_zero", {48'd0, mem_addr}, 64'd0);
      if (mem_wr_en) begin
        mem[mem_addr] = mem_wdata;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {48'd0, mem_addr}, {48'd0, e.addr});
          check("wr_data", {32'd0, mem_wdata}, {32'd0, e.data});
        end
      end
      if (done) done_cnt++;
    end
  end

  // Behavioural row-parallel FP32 datapath.
  initial begin
    int           row_wait, cell_wait, pcnt, rdy_cnt, out_cnt, cyc, rdy_cyc;
    logic         row_got, cell_got, row_seen, cell_seen, rdy_owed, resume_armed;
    logic [W*K-1:0] row_val, row_snap;
    logic [W-1:0] cell_val, cell_snap;
    real          acc [K];
    cyc = 0; rdy_cyc = 0; row_wait = 0; cell_wait = 0; pcnt = 0; rdy_cnt = -1; out_cnt = 0;
    row_got = 0; cell_got = 0; row_seen = 0; cell_seen = 0; rdy_owed = 1; resume_armed = 0;
    row_val = '0; row_snap = '0; cell_val = '0; cell_snap = '0;
    for (int n = 0; n < K; n++) acc[n] = 0.0;
    dp_row_ack = 0; dp_cell_ack = 0; dp_ready = 0; dp_out_stb = 0; dp_out_row = '0;
    forever begin
      @(negedge clk);
      cyc++;
      dp_row_ack = 0; dp_cell_ack = 0; dp_ready = 0; dp_out_stb = 0;
      if (rst) begin
        row_wait = 0; cell_wait = 0; pcnt = 0; rdy_cnt = 1; out_cnt = 0;
        row_got = 0; cell_got = 0; row_seen = 0; cell_seen = 0; rdy_owed = 1; resume_armed = 0;
        for (int n = 0; n < K; n++) acc[n] = 0.0;
      end else begin
        if (rdy_cnt > 0) rdy_cnt--;
        else if (rdy_cnt == 0) begin
          dp_ready = 1; rdy_owed = 0; rdy_cyc = cyc; rdy_cnt = -1;
        end
        if (dp_row_stb) begin
          check("row_no_x", {63'd0, $isunknown(dp_row)}, 64'd0);
          if (!row_seen) begin
            row_seen = 1; row_snap = dp_row;
            check("stb_before_ready", {63'd0, rdy_owed}, 64'd0);
            if (resume_armed) begin
              check("resume_cycle", 64'(cyc), 64'(rdy_cyc + 1));
              resume_armed = 0;
            end
          end else check("row_stable", dp_row, row_snap);
          if (row_got) check("row_stb_after_ack", {63'd0, dp_row_stb}, 64'd0);
          else if (row_wait >= row_delay) begin
            dp_row_ack = 1; row_got = 1; row_val = dp_row;
          end else row_wait++;
        end
        if (dp_cell_stb) begin
          check("cell_no_x", {63'd0, $isunknown(dp_cell)}, 64'd0);
          if (!cell_seen) begin
            cell_seen = 1; cell_snap = dp_cell;
          end else check("cell_stable", {32'd0, dp_cell}, {32'd0, cell_snap});
          if (cell_got) check("cell_stb_after_ack", {63'd0, dp_cell_stb}, 64'd0);
          else begin
            dp_cell_ack = 1; cell_got = 1; cell_val = dp_cell;
          end
        end
        if (row_got && cell_got) begin
          for (int n = 0; n < K; n++) acc[n] = acc[n] + f2r(cell_val) * f2r(row_val[W*n +: W]);
          row_got = 0; cell_got = 0; row_seen = 0; cell_seen = 0; row_wait = 0; cell_wait = 0;
          issue_cnt++; pcnt++; rdy_owed = 1;
          if (slow_first) begin
            rdy_cnt = 10; slow_first = 0; resume_armed = 1;
          end else rdy_cnt = 0;
          if (pcnt == K) begin
            out_cnt = 2; pcnt = 0;
          end
        end
        if (out_cnt > 0) begin
          out_cnt--;
          if (out_cnt == 0) begin
            for (int n = 0; n < K; n++) begin
              dp_out_row[W*n +: W] = r2f(acc[n]);
              acc[n] = 0.0;
            end
            dp_out_stb = 1;
          end
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_busy"},     {63'd0, busy},        64'd0);
    check({tag, "_done"},     {63'd0, done},        64'd0);
    check({tag, "_addr"},     {48'd0, mem_addr},    64'd0);
    check({tag, "_rd_en"},    {63'd0, mem_rd_en},   64'd0);
    check({tag, "_wr_en"},    {63'd0, mem_wr_en},   64'd0);
    check({tag, "_wdata"},    {32'd0, mem_wdata},   64'd0);
    check({tag, "_row"},      dp_row,               64'd0);
    check({tag, "_row_stb"},  {63'd0, dp_row_stb},  64'd0);
    check({tag, "_cell"},     {32'd0, dp_cell},     64'd0);
    check({tag, "_cell_stb"}, {63'd0, dp_cell_stb}, 64'd0);
  endtask

  task automatic push_expected(input logic [AW-1:0] bc);
    wr_t e;
    for (int n = 0; n < 4; n++) begin
      e.addr = bc + AW'(n);
      e.data = C_EXP[n];
      exp_q.push_back(e);
    end
  endtask

  task automatic run(input logic [AW-1:0] bc, input int extra_start);
    int d0, i0;
    bit seen;
    seen = 0;
    push_expected(bc);
    d0 = done_cnt;
    i0 = issue_cnt;
    base_a = 16'h0100; base_b = 16'h0200; base_c = bc; start = 1;
    @(negedge clk);
    start = 0; base_a = 16'h7777; base_b = 16'h7777; base_c = 16'h7777;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clk);
      if (t == extra_start) begin
        start = 1; base_c = 16'h0444;
      end else if (t == extra_start + 1) start = 0;
      if (done) seen = 1;
    end
    start = 0;
    check("done_seen", {63'd0, seen}, 64'd1);
    check("busy_at_done", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("busy_after_done", {63'd0, busy}, 64'd0);
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
    check("issue_count", 64'(issue_cnt - i0), 64'(K * K));
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic abort_in_write();
    bit seen;
    seen = 0;
    push_expected(16'h0350);
    base_a = 16'h0100; base_b = 16'h0200; base_c = 16'h0350; start = 1;
    @(negedge clk);
    start = 0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clk);
      if (mem_wr_en) seen = 1;
    end
    check("abort_reached_write", {63'd0, seen}, 64'd1);
    rst = 1;
    @(negedge clk);
    check_zero("abort");
    exp_q.delete();
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1; start = 0; base_a = '0; base_b = '0; base_c = '0;
    mem[16'h0100] = 32'h3F800000; mem[16'h0101] = 32'h40000000;
    mem[16'h0102] = 32'h40400000; mem[16'h0103] = 32'h40800000;
    mem[16'h0200] = 32'h40A00000; mem[16'h0201] = 32'h40C00000;
    mem[16'h0202] = 32'h40E00000; mem[16'h0203] = 32'h41000000;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 0;
    repeat (3) @(negedge clk);

    run(16'h0300, -1);
    row_delay = 3;
    run(16'h0310, -1);
    row_delay = 0;
    slow_first = 1;
    run(16'h0320, -1);
    run(16'hFFFF, -1);
    run(16'h0330, 15);
    abort_in_write();
    run(16'h0360, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
